// File: rtl/two_phase_counter_if.sv
// Strobe/control and status bundle of the two-phase counter.
// The sequencer drives the strobes through the master modport.
// The counter drives its registers back through the slave modport.
interface two_phase_counter_if #(
    parameter int WIDTH = 4
) ();
    // Phase strobes and count controls, all sampled on the rising clock edge
    logic             step_a;
    logic             step_b;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // Counter state and status flags
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_slave;
    logic             carry;
    logic             tc;
    logic             settled;
    logic             overlap;

    modport master (
        output step_a, step_b, en, up, load, load_val,
        input  q, q_slave, carry, tc, settled, overlap
    );

    modport slave (
        input  step_a, step_b, en, up, load, load_val,
        output q, q_slave, carry, tc, settled, overlap
    );
endinterface

// File: rtl/two_phase_counter.sv
// Master/slave two-phase counter for the MCS-4 timing and sequencing logic.
// A step_a strobe loads the master with the next value derived from the
// slave. A step_b strobe copies the master into the slave, which completes
// one count. Because the next value is always derived from the slave,
// repeating step_a on its own never advances the count twice.
module two_phase_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 2 ** WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic                 sysclk,
    input  logic                 poc_n,
    two_phase_counter_if.slave   bus
);
    // MODULUS can be 2**WIDTH, so it needs one bit more than the count
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_slave_reg;
    logic             carry_reg;
    logic             settled_reg;
    logic             overlap_reg;

    logic [WIDTH-1:0] master_next;
    logic             carry_next;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_red;

    // Fold an out-of-range load value back into 0..MODULUS-1
    assign load_ext = {1'b0, bus.load_val} % MOD_EXT;
    assign load_red = load_ext[WIDTH-1:0];

    // Next master value and wrap flag, always computed from the slave
    always_comb begin
        master_next = q_slave_reg;
        carry_next  = 1'b0;
        if (bus.load) begin
            master_next = load_red;
            carry_next  = 1'b0;
        end else if (bus.en && bus.up) begin
            carry_next  = (q_slave_reg == MAX_VAL);
            master_next = (q_slave_reg == MAX_VAL) ? ZERO_VAL : q_slave_reg + ONE_VAL;
        end else if (bus.en) begin
            carry_next  = (q_slave_reg == ZERO_VAL);
            master_next = (q_slave_reg == ZERO_VAL) ? MAX_VAL : q_slave_reg - ONE_VAL;
        end
    end

    // Master and carry: loaded on step_a, held otherwise
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            q_reg     <= RST_VAL;
            carry_reg <= 1'b0;
        end else if (bus.step_a) begin
            q_reg     <= master_next;
            carry_reg <= carry_next;
        end
    end

    // Slave: takes the pre-edge master value on step_b
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            q_slave_reg <= RST_VAL;
        end else if (bus.step_b) begin
            q_slave_reg <= q_reg;
        end
    end

    // Settled and overlap flags; step_a always unsettles and a same-cycle
    // step_a/step_b is recorded as a sticky sequencing error
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            settled_reg <= 1'b1;
            overlap_reg <= 1'b0;
        end else begin
            if (bus.step_a) begin
                settled_reg <= 1'b0;
            end else if (bus.step_b) begin
                settled_reg <= 1'b1;
            end
            if (bus.step_a && bus.step_b) begin
                overlap_reg <= 1'b1;
            end
        end
    end

    assign bus.q       = q_reg;
    assign bus.q_slave = q_slave_reg;
    assign bus.carry   = carry_reg;
    assign bus.settled = settled_reg;
    assign bus.overlap = overlap_reg;
    // Terminal count follows the current direction input
    assign bus.tc      = bus.up ? (q_reg == MAX_VAL) : (q_reg == ZERO_VAL);
endmodule

// File: tb/tb_two_phase_counter.sv
// Self-checking bench for two_phase_counter (WIDTH=4, MODULUS=10).
// A reference model of master, slave and flags is advanced once per clock.
// Every DUT output is compared against the model after each clock.
module tb_two_phase_counter;
    localparam int W  = 4;
    localparam int M  = 10;
    localparam int RV = 0;

    logic sysclk = 1'b0;
    logic poc_n;

    always #5 sysclk = ~sysclk;

    two_phase_counter_if #(.WIDTH(W)) bus ();

    two_phase_counter #(
        .WIDTH     (W),
        .MODULUS   (M),
        .RESET_VAL (RV)
    ) dut (
        .sysclk (sysclk),
        .poc_n  (poc_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_master  = RV;
    int m_slave   = RV;
    int m_carry   = 0;
    int m_settled = 1;
    int m_overlap = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, update the model at the
    // rising edge, compare at the next falling edge
    task automatic cyc(input bit rn, input bit a, input bit b, input bit e,
                       input bit u, input bit l, input int lv, input string tag);
        int nm, ns, nc, nset, nov;
        poc_n        = rn;
        bus.step_a   = a;
        bus.step_b   = b;
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = W'(lv);
        @(posedge sysclk);
        nm = m_master; ns = m_slave; nc = m_carry; nset = m_settled; nov = m_overlap;
        if (!rn) begin
            nm = RV; ns = RV; nc = 0; nset = 1; nov = 0;
        end else begin
            if (a) begin
                if (l) begin
                    nm = lv % M; nc = 0;
                end else if (e && u) begin
                    nm = (m_slave + 1) % M; nc = (m_slave == M - 1) ? 1 : 0;
                end else if (e) begin
                    nm = (m_slave + M - 1) % M; nc = (m_slave == 0) ? 1 : 0;
                end else begin
                    nm = m_slave; nc = 0;
                end
                nset = 0;
            end
            if (b) begin
                ns = m_master;
                if (!a) nset = 1;
            end
            if (a && b) nov = 1;
        end
        m_master = nm; m_slave = ns; m_carry = nc; m_settled = nset; m_overlap = nov;
        @(negedge sysclk);
        chk({tag, ".q"},       32'(bus.q),       m_master);
        chk({tag, ".q_slave"}, 32'(bus.q_slave), m_slave);
        chk({tag, ".carry"},   32'(bus.carry),   m_carry);
        chk({tag, ".settled"}, 32'(bus.settled), m_settled);
        chk({tag, ".overlap"}, 32'(bus.overlap), m_overlap);
        chk({tag, ".tc"},      32'(bus.tc),
            u ? ((m_master == M - 1) ? 1 : 0) : ((m_master == 0) ? 1 : 0));
        $display("txn %s rn=%0d a=%0d b=%0d en=%0d up=%0d ld=%0d lv=%0d -> q=%0d qs=%0d c=%0d set=%0d ov=%0d tc=%0d",
                 tag, rn, a, b, e, u, l, lv, bus.q, bus.q_slave, bus.carry,
                 bus.settled, bus.overlap, bus.tc);
    endtask

    // A complete count step: step_a then step_b
    task automatic pair(input bit e, input bit u, input bit l, input int lv, input string tag);
        cyc(1, 1, 0, e, u, l, lv, {tag, "_a"});
        cyc(1, 0, 1, e, u, l, lv, {tag, "_b"});
    endtask

    initial begin
        poc_n = 1'b0;
        bus.step_a = 1'b0; bus.step_b = 1'b0; bus.en = 1'b0;
        bus.up = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        @(negedge sysclk);

        // Reset held for two cycles
        cyc(0, 0, 0, 0, 0, 0, 0, "rst0");
        cyc(0, 0, 0, 0, 0, 0, 0, "rst1");

        // Up count through the wrap: 1..9,0,1,2
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0, 1, 1, 0, 0, "up_a");
            if (i == 9) chk("wrap_carry", 32'(bus.carry), 1);
            if (i == 8) chk("pre_wrap_carry", 32'(bus.carry), 0);
            cyc(1, 0, 1, 1, 1, 0, 0, "up_b");
        end
        chk("up_end_q", 32'(bus.q), 2);

        // Down count: load 0, then 0->9->8->7
        pair(0, 0, 1, 0, "ld0");
        chk("ld0_tc", 32'(bus.tc), 1);
        cyc(1, 1, 0, 1, 0, 0, 0, "dn_a");
        chk("dn_wrap_q", 32'(bus.q), 9);
        chk("dn_wrap_carry", 32'(bus.carry), 1);
        cyc(1, 0, 1, 1, 0, 0, 0, "dn_b");
        pair(1, 0, 0, 0, "dn");
        pair(1, 0, 0, 0, "dn");
        chk("dn_end_q", 32'(bus.q), 7);

        // Out-of-range load and load priority over enable
        pair(0, 1, 1, 13, "ld13");
        chk("ld13_q", 32'(bus.q), 3);
        pair(1, 1, 1, 15, "ld15en");
        chk("ld15_q", 32'(bus.q), 5);
        chk("ld15_carry", 32'(bus.carry), 0);

        // Repeated step_a from slave=4 must not double count
        pair(0, 1, 1, 4, "ld4");
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 1, 0, 0, "rep_a");
        chk("rep_q", 32'(bus.q), 5);
        chk("rep_settled", 32'(bus.settled), 0);
        for (int i = 0; i < 2; i++) cyc(1, 0, 1, 1, 1, 0, 0, "rep_b");
        chk("rep_qs", 32'(bus.q_slave), 5);
        chk("rep_settled2", 32'(bus.settled), 1);

        // Overlap: slave=2, master=3, then both strobes together
        pair(0, 1, 1, 2, "ld2");
        cyc(1, 1, 0, 1, 1, 0, 0, "ov_pre");
        cyc(1, 1, 1, 1, 1, 0, 0, "ov");
        chk("ov_q", 32'(bus.q), 3);
        chk("ov_qs", 32'(bus.q_slave), 3);
        chk("ov_flag", 32'(bus.overlap), 1);
        pair(1, 1, 0, 0, "ov_hold");
        chk("ov_sticky", 32'(bus.overlap), 1);

        // Mid-sequence reset with a coincident step_b
        pair(0, 1, 1, 5, "ld5");
        cyc(1, 1, 0, 1, 1, 0, 0, "mid_a");
        chk("mid_q", 32'(bus.q), 6);
        cyc(0, 0, 1, 1, 1, 0, 0, "mid_rst");
        chk("mid_q_rst", 32'(bus.q), RV);
        chk("mid_qs_rst", 32'(bus.q_slave), RV);
        chk("mid_ov_clr", 32'(bus.overlap), 0);

        // Randomized strobes and controls against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) != 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 15)),
                "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/two_phase_counter.md
Name: two_phase_counter

Overview:
- Parametrised, multi-bit, master/slave two-phase counter for the MCS-4 timing and sequencing logic, e.g. cycle, register-pointer and stack-pointer counters.
- Each count step takes one `step_a` pulse and one `step_b` pulse, matching the 4004 two-phase clocking.
- `step_a` loads the master with the next value computed from the slave; `step_b` copies the master into the slave.
- Adds width, modulus, up/down, parallel load, carry and an overlap-error flag.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1 (2..2**WIDTH).
- RESET_VAL, 0, value of master and slave after reset (< MODULUS).

Ports:
- sysclk  input  1  system clock; all state changes on rising edge.
- poc_n  input  1  synchronous active-low reset (power-on clear), sampled on rising sysclk.
- step_a  input  1  phase A strobe: master <= next(slave).
- step_b  input  1  phase B strobe: slave <= master.
- en  input  1  count enable, sampled with step_a.
- up  input  1  1 = increment, 0 = decrement; sampled with step_a.
- load  input  1  parallel load, sampled with step_a; overrides en.
- load_val  input  WIDTH  value for load; values >= MODULUS are reduced to load_val mod MODULUS.
- q  output  WIDTH  master register (visible count).
- q_slave  output  WIDTH  slave register.
- carry  output  1  registered; set on the step_a that wraps (up: MODULUS-1 -> 0; down: 0 -> MODULUS-1).
- tc  output  1  combinational; 1 when q == MODULUS-1 (up=1) or q == 0 (up=0).
- settled  output  1  registered; 1 when slave equals master and no step_a has occurred since the last step_b.
- overlap  output  1  sticky error; set when step_a and step_b are both high in the same cycle.

Behaviour:
- Reset (poc_n=0 at rising edge): q = q_slave = RESET_VAL; carry = 0; settled = 1; overlap = 0. Reset has priority over all strobes, including mid-sequence (after step_a, before step_b).
- step_a=1 (reset inactive), priority order:
  - load=1: q <= load_val mod MODULUS; carry <= 0.
  - else en=1, up=1: q <= (q_slave == MODULUS-1) ? 0 : q_slave+1; carry <= (q_slave == MODULUS-1).
  - else en=1, up=0: q <= (q_slave == 0) ? MODULUS-1 : q_slave-1; carry <= (q_slave == 0).
  - else: q <= q_slave; carry <= 0.
  - In all cases settled <= 0.
- step_a=0: q and carry hold. Carry stays high until the next step_a or reset, so downstream stages sample it on their own step_a.
- step_b=1: q_slave <= q, using the pre-edge value of q. settled <= 1 unless step_a is also high.
- step_a and step_b both high in one cycle:
  - Both updates use pre-edge values: master gets next(old slave), slave gets old master.
  - settled <= 0; overlap <= 1, held until reset.
- Repeated step_a without step_b: master is recomputed from the unchanged slave, so there is no double count. Repeated step_b is idempotent.
- Count changes only when step_a is followed by step_b. Latency: q updates 1 cycle after step_a; q_slave updates 1 cycle after step_b.
- WIDTH=1, MODULUS=2, en=1, up=1 reproduces the single-bit toggle stage: q toggles once per step_a/step_b pair.
- All arithmetic is modulo MODULUS; no intermediate value is ever >= MODULUS.

Test Plan:
- Reset and count: WIDTH=4, MODULUS=10, RESET_VAL=0; poc_n low 2 cycles, then 12 step_a/step_b pairs with en=1, up=1 -> q sequence 1..9,0,1,2; carry high only after the 10th step_a (9->0); q_slave lags q until each step_b.
- Down count: load_val=0, load=1 with step_a, then step_b; then en=1, up=0, 3 pairs -> q = 0,9,8,7; carry set on the 0->9 step_a; tc=1 while q=0 with up=0.
- Load and overflow: load_val=13 with MODULUS=10 -> q=3. Load with en=1 -> load wins, carry=0.
- Repeated phases: step_a 3 times without step_b (en=1, slave=4) -> q stays 5; settled=0. Then step_b twice -> q_slave=5; settled=1.
- Overlap: slave=2, master=3, step_a and step_b in the same cycle with en=1 -> q=3, q_slave=3, overlap=1; overlap stays 1 until poc_n low.
- Mid-sequence reset: step_a (q=6, slave=5), then poc_n low before step_b -> q = q_slave = RESET_VAL, settled=1, carry=0. A step_b in the same cycle as reset is ignored.
